ddc_iq_accum: RTL and testbench

- Integrate-and-dump decimator directly downstream of the quad-DDC summing stage.
- Consumes its 64-bit sign-extended IQ word and valid strobe, and accumulates a programmable number of samples per channel.
- Pushes each completed I/Q sum into a 2-entry output buffer, drained over an AXI4-Stream master towards the DMA/packetiser.
- Detects and counts dumps lost to backpressure.

---
 rtl/ddc_iq_accum_if.sv | 18 +
 rtl/ddc_iq_accum.sv | 179 +++++++++++++++++
 tb/tb_ddc_iq_accum.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ddc_iq_accum_if.sv
// AXI4-Stream master bundle for the ddc_iq_accum decimator output.
// With DDC_ACC_TSTAMP_EN defined, a 32-bit tuser carries the frame index.
interface ddc_iq_accum_if #(
  parameter int ACC_W = 48
);
  logic [2*ACC_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
`ifdef DDC_ACC_TSTAMP_EN
  logic [31:0]        tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);
`else
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/ddc_iq_accum.sv
// Integrate-and-dump decimator for the quad-DDC IQ stream.
// Sums cur_len samples per component, pushes {Q_sum, I_sum} into a 2-entry
// FIFO drained over AXI4-Stream, and counts dumps lost to backpressure.
// Optional: DDC_ACC_TSTAMP_EN adds a per-dump frame index on m_axis.tuser.
module ddc_iq_accum #(
  parameter int ACC_W = 48,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [63:0]      data_in,
  input  logic             valid_in,
  input  logic [LEN_W-1:0] acc_len,
  input  logic             len_valid,
  input  logic             resync,
  ddc_iq_accum_if.master   m_axis,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int W_W = 2 * ACC_W;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_i_q, acc_q_q;
  logic [LEN_W-1:0]   cnt_q, cur_len_q, pend_len_q;
  logic               pend_flag_q;

  logic [W_W-1:0]     mem_q [2];
  logic               rd_q, wr_q;
  logic [1:0]         count_q;

  logic [LEN_W-1:0]   new_len;
  logic [ACC_W-1:0]   sum_i, sum_q;
  logic               running, last, dump, boundary;
  logic               full, pop, push, drop;

`ifdef DDC_ACC_TSTAMP_EN
  logic [31:0]        frame_q;
  logic [31:0]        tag_q [2];
`endif

  // Shared datapath decode: new length, per-component sums and frame events.
  always_comb begin
    new_len  = (acc_len == '0) ? LEN_W'(1) : acc_len;
    sum_i    = acc_i_q + {{(ACC_W-32){data_in[31]}}, data_in[31:0]};
    sum_q    = acc_q_q + {{(ACC_W-32){data_in[63]}}, data_in[63:32]};
    running  = (state_q == RUN);
    last     = (cnt_q == LEN_W'(cur_len_q - LEN_W'(1)));
    // A resync discards the coincident sample, so it suppresses the dump.
    dump     = running && valid_in && !resync && last;
    boundary = running && (resync || dump);
    full     = (count_q == 2'd2);
    pop      = m_axis.tvalid && m_axis.tready;
    // Head slot is freed by the same-edge pop, so a full FIFO can still accept.
    push     = dump && (!full || pop);
    drop     = dump && full && !pop;
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: leave IDLE on the first length strobe, then stay in RUN.
  // NOTE: state_d gets a default first so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && len_valid) state_d = RUN;
  end

  // Frame length bookkeeping: immediate out of IDLE, else deferred to a boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_len_q   <= LEN_W'(1);
      pend_len_q  <= LEN_W'(1);
      pend_flag_q <= 1'b0;
    end else if (!running) begin
      if (len_valid) begin
        cur_len_q   <= new_len;
        pend_len_q  <= new_len;
        pend_flag_q <= 1'b0;
      end
    end else if (boundary) begin
      if (len_valid) begin
        cur_len_q   <= new_len;
        pend_len_q  <= new_len;
        pend_flag_q <= 1'b0;
      end else if (pend_flag_q) begin
        cur_len_q   <= pend_len_q;
        pend_flag_q <= 1'b0;
      end
    end else if (len_valid) begin
      pend_len_q  <= new_len;
      pend_flag_q <= 1'b1;
    end
  end

  // Accumulators and sample counter; cleared at every frame boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
    end else if (boundary) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
    end else if (running && valid_in) begin
      acc_i_q <= sum_i;
      acc_q_q <= sum_q;
      cnt_q   <= cnt_q + LEN_W'(1);
    end
  end

  // Two-entry output FIFO; the head entry drives the stream directly.
  // NOTE: the storage is reset on purpose so tdata reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (pop) rd_q <= ~rd_q;
      if (push) begin
        mem_q[wr_q] <= {sum_q, sum_i};
        wr_q        <= ~wr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_axis.tvalid = (count_q != 2'd0);
  assign m_axis.tdata  = mem_q[rd_q];

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef DDC_ACC_TSTAMP_EN
  // Frame index: counts every dump (dropped included), cleared by resync.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     frame_q <= '0;
    else if (resync) frame_q <= '0;
    else if (dump)   frame_q <= frame_q + 32'd1;
  end

  // Frame index storage kept in step with the data FIFO slots.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else if (push) begin
      tag_q[wr_q] <= frame_q;
    end
  end

  assign m_axis.tuser = tag_q[rd_q];
`endif

endmodule

// File: tb/tb_ddc_iq_accum.sv
// Directed self-checking bench for ddc_iq_accum.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_ddc_iq_accum;

  localparam int ACC_W = 48;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [63:0]      data_in;
  logic             valid_in;
  logic [LEN_W-1:0] acc_len;
  logic             len_valid;
  logic             resync;
  logic             overflow;
  logic [15:0]      drop_cnt;

  int total = 0;
  int bad   = 0;

  ddc_iq_accum_if #(.ACC_W(ACC_W)) axis ();

  ddc_iq_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .acc_len   (acc_len),
    .len_valid (len_valid),
    .resync    (resync),
    .m_axis    (axis),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] word(input logic signed [47:0] i, input logic signed [47:0] q);
    return {q, i};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle with a valid sample; strobes are cleared afterwards.
  task automatic sample(input logic [31:0] i, input logic [31:0] q);
    data_in  = {q, i};
    valid_in = 1'b1;
    cyc();
    valid_in  = 1'b0;
    len_valid = 1'b0;
    resync    = 1'b0;
  endtask

  // Abort the frame and load a new length that applies at once.
  task automatic restart(input logic [LEN_W-1:0] len);
    acc_len   = len;
    len_valid = 1'b1;
    resync    = 1'b1;
    cyc();
    len_valid = 1'b0;
    resync    = 1'b0;
  endtask

  logic [47:0] big;

  initial begin
    rstn = 1'b0; data_in = '0; valid_in = 1'b0; acc_len = '0;
    len_valid = 1'b0; resync = 1'b0; axis.tready = 1'b1;
    cyc(); cyc();
    check("rst_tvalid", 96'(axis.tvalid), 96'(0));
    check("rst_tdata", axis.tdata, 96'(0));
    check("rst_overflow", 96'(overflow), 96'(0));
    check("rst_drop_cnt", 96'(drop_cnt), 96'(0));
    rstn = 1'b1;
    cyc();

    // IDLE ignores samples.
    sample(32'd5, 32'd5);
    check("idle_ignored", 96'(axis.tvalid), 96'(0));

    // Length 4: I = 1..4, Q = -1..-4.
    acc_len = 16'd4; len_valid = 1'b1; cyc(); len_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      sample(32'(k), 32'(-k));
      check("len4_no_early_dump", 96'(axis.tvalid), 96'(0));
    end
    sample(32'd4, -32'sd4);
    check("len4_tvalid", 96'(axis.tvalid), 96'(1));
    check("len4_tdata", axis.tdata, {48'hFFFFFFFFFFF6, 48'd10});
    cyc();
    check("len4_popped", 96'(axis.tvalid), 96'(0));

    // Length 0 behaves as 1; extremes are sign-extended.
    restart(16'd0);
    for (int k = 0; k < 3; k++) begin
      sample(32'h7FFFFFFF, 32'h80000000);
      check("len1_tvalid", 96'(axis.tvalid), 96'(1));
      check("len1_tdata", axis.tdata, {48'hFFFF80000000, 48'h00007FFFFFFF});
    end
    cyc();

    // Maximum length with maximum positive samples.
    restart(16'hFFFF);
    for (int k = 0; k < 65534; k++) sample(32'h7FFFFFFF, 32'h7FFFFFFF);
    check("maxlen_no_early_dump", 96'(axis.tvalid), 96'(0));
    sample(32'h7FFFFFFF, 32'h7FFFFFFF);
    big = 48'd65535 * 48'h7FFFFFFF;
    check("maxlen_tvalid", 96'(axis.tvalid), 96'(1));
    check("maxlen_tdata", axis.tdata, {big, big});
    cyc();

    // Backpressure: length 2, 8 samples, two beats kept, two dropped.
    axis.tready = 1'b0;
    restart(16'd2);
    for (int k = 1; k <= 8; k++) begin
      sample(32'(k), 32'(-k));
      if (k == 4) check("bp_two_held", axis.tdata, word(3, -3));
      if (k == 6) check("bp_first_drop", 96'(drop_cnt), 96'(1));
    end
    check("bp_tvalid", 96'(axis.tvalid), 96'(1));
    check("bp_head_stable", axis.tdata, word(3, -3));
    check("bp_overflow", 96'(overflow), 96'(1));
    check("bp_drop_cnt", 96'(drop_cnt), 96'(2));
    axis.tready = 1'b1;
    cyc();
    check("bp_second_tvalid", 96'(axis.tvalid), 96'(1));
    check("bp_second_tdata", axis.tdata, word(7, -7));
    cyc();
    check("bp_drained", 96'(axis.tvalid), 96'(0));

    // Pending length: frame of 4 completes, later frames use 2 and then 3.
    restart(16'd4);
    sample(32'd1, 32'd2);
    sample(32'd1, 32'd2);
    acc_len = 16'd2; len_valid = 1'b1; cyc(); len_valid = 1'b0;
    sample(32'd1, 32'd2);
    check("pend_no_early_dump", 96'(axis.tvalid), 96'(0));
    sample(32'd1, 32'd2);
    check("pend_len4_tdata", axis.tdata, word(4, 8));
    sample(32'd1, 32'd2);
    check("pend_len2_mid", 96'(axis.tvalid), 96'(0));
    acc_len = 16'd3; len_valid = 1'b1;
    sample(32'd1, 32'd2);
    check("pend_len2_tdata", axis.tdata, word(2, 4));
    sample(32'd1, 32'd2);
    sample(32'd1, 32'd2);
    check("dumpcyc_len_mid", 96'(axis.tvalid), 96'(0));
    sample(32'd1, 32'd2);
    check("dumpcyc_len3_tdata", axis.tdata, word(3, 6));
    check("overflow_sticky", 96'(overflow), 96'(1));
    cyc();

    // Resync with a coincident sample discards the partial frame.
    restart(16'd3);
    sample(32'd1, 32'd1);
    sample(32'd1, 32'd1);
    resync = 1'b1;
    sample(32'd100, 32'd100);
    check("resync_no_beat", 96'(axis.tvalid), 96'(0));
    sample(32'd1, -32'sd1);
    sample(32'd2, -32'sd2);
    check("resync_no_early_dump", 96'(axis.tvalid), 96'(0));
    sample(32'd3, -32'sd3);
    check("resync_tdata", axis.tdata, word(6, -6));
`ifdef DDC_ACC_TSTAMP_EN
    check("resync_tuser", 96'(axis.tuser), 96'(0));
`endif
    cyc();

    // Reset mid-frame loses the partial sum and clears the flags.
    sample(32'd9, 32'd9);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    check("midrst_tvalid", 96'(axis.tvalid), 96'(0));
    check("midrst_overflow", 96'(overflow), 96'(0));
    check("midrst_drop_cnt", 96'(drop_cnt), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
